// File: rtl/fpu_wb_sched_if.sv
// Issue / writeback / scoreboard bundle between the FP issue stage, the FPU
// result bundle and the writeback scheduler.
interface fpu_wb_sched_if;
    logic           issue_valid;
    logic [2:0]     issue_op;
    logic [4:0]     issue_rd;
    logic           issue_ready;
    logic           flush;
    logic [223:0]   fpu_results;
    logic           wb_valid;
    logic [4:0]     wb_rd;
    logic           wb_int;
    logic [31:0]    wb_data;
    logic [31:0]    busy;

    modport master (
        output issue_valid, issue_op, issue_rd, flush, fpu_results,
        input  issue_ready, wb_valid, wb_rd, wb_int, wb_data, busy
    );

    modport slave (
        input  issue_valid, issue_op, issue_rd, flush, fpu_results,
        output issue_ready, wb_valid, wb_rd, wb_int, wb_data, busy
    );
endinterface

// File: rtl/fpu_wb_sched.sv
// Multi-cycle FP writeback scheduler: per-op fixed-latency slot pipeline,
// single registered writeback port and a per-register busy scoreboard.
module fpu_wb_sched #(
    parameter int unsigned LAT_FADD   = 2,
    parameter int unsigned LAT_FSUB   = 2,
    parameter int unsigned LAT_FDIV   = 6,
    parameter int unsigned LAT_FSQRT  = 6,
    parameter int unsigned LAT_FCVTWS = 3,
    parameter int unsigned LAT_FCVTSW = 2,
    parameter int unsigned LAT_FMUL   = 2,
    parameter int unsigned MAX_LAT    = 8
) (
    input  logic           clk,
    input  logic           rst,
    fpu_wb_sched_if.slave  sif
);

    localparam logic [2:0] OP_FCVTWS = 3'd4;
    localparam logic [2:0] OP_NONE   = 3'd7;

    function automatic int unsigned lat_of(input logic [2:0] op);
        case (op)
            3'd0:    return LAT_FADD;
            3'd1:    return LAT_FSUB;
            3'd2:    return LAT_FDIV;
            3'd3:    return LAT_FSQRT;
            3'd4:    return LAT_FCVTWS;
            3'd5:    return LAT_FCVTSW;
            3'd6:    return LAT_FMUL;
            default: return 0;
        endcase
    endfunction

    logic [MAX_LAT-1:0]        r_slot_vld;
    logic [MAX_LAT-1:0][2:0]   r_slot_op;
    logic [MAX_LAT-1:0][4:0]   r_slot_rd;
    logic [31:0]               r_busy;
    logic                      r_wb_valid;
    logic [4:0]                r_wb_rd;
    logic                      r_wb_int;
    logic [31:0]               r_wb_data;

    int unsigned               w_lat;
    logic                      w_nop;
    logic                      w_collide;
    logic                      w_ready;
    logic                      w_accept;
    logic [31:0]               w_slice;
    logic [31:0]               w_busy_nxt;

    // An op of latency L lands in slot[0] in cycle L; a live slot[L] now
    // would land there in the same cycle, so it blocks the issue.
    always_comb begin
        w_lat     = lat_of(sif.issue_op);
        w_nop     = (sif.issue_op == OP_NONE);
        w_collide = 1'b0;
        for (int unsigned i = 0; i < MAX_LAT; i++) begin
            if (i == w_lat && r_slot_vld[i]) begin
                w_collide = 1'b1;
            end
        end
        w_ready  = !sif.flush && (w_nop || (!w_collide && !r_busy[sif.issue_rd]));
        w_accept = sif.issue_valid && w_ready && !w_nop;
    end

    always_comb begin
        case (r_slot_op[0])
            3'd0:    w_slice = sif.fpu_results[31:0];
            3'd1:    w_slice = sif.fpu_results[63:32];
            3'd2:    w_slice = sif.fpu_results[95:64];
            3'd3:    w_slice = sif.fpu_results[127:96];
            3'd4:    w_slice = sif.fpu_results[159:128];
            3'd5:    w_slice = sif.fpu_results[191:160];
            3'd6:    w_slice = sif.fpu_results[223:192];
            default: w_slice = '0;
        endcase
    end

    // Clear for the retiring entry first so a same-index set overrides it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_slot_vld[0]) begin
            w_busy_nxt[r_slot_rd[0]] = 1'b0;
        end
        if (w_accept) begin
            w_busy_nxt[sif.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_vld <= '0;
            r_slot_op  <= '0;
            r_slot_rd  <= '0;
            r_busy     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_int   <= 1'b0;
            r_wb_data  <= '0;
        end else if (sif.flush) begin
            r_slot_vld <= '0;
            r_busy     <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_slot_vld <= {1'b0, r_slot_vld[MAX_LAT-1:1]};
            r_slot_op  <= {3'd0, r_slot_op[MAX_LAT-1:1]};
            r_slot_rd  <= {5'd0, r_slot_rd[MAX_LAT-1:1]};
            if (w_accept) begin
                for (int unsigned i = 0; i < MAX_LAT; i++) begin
                    if (i + 1 == w_lat) begin
                        r_slot_vld[i] <= 1'b1;
                        r_slot_op[i]  <= sif.issue_op;
                        r_slot_rd[i]  <= sif.issue_rd;
                    end
                end
            end
            r_wb_valid <= r_slot_vld[0];
            if (r_slot_vld[0]) begin
                r_wb_rd   <= r_slot_rd[0];
                r_wb_int  <= (r_slot_op[0] == OP_FCVTWS);
                r_wb_data <= w_slice;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign sif.issue_ready = w_ready;
    assign sif.wb_valid    = r_wb_valid;
    assign sif.wb_rd       = r_wb_rd;
    assign sif.wb_int      = r_wb_int;
    assign sif.wb_data     = r_wb_data;
    assign sif.busy        = r_busy;

endmodule

// File: doc/fpu_wb_sched.md
Name: fpu_wb_sched

Overview:
- Sits directly downstream of the FPU's multi-cycle result bundle (224-bit, seven 32-bit slices).
- Tracks every issued multi-cycle FP op with its own fixed latency and selects the matching slice when the result matures.
- Presents a single registered writeback port and arbitrates issue so that no two ops complete in the same cycle.
- Maintains a per-register busy scoreboard for the hazard unit.

Parameters:
- LAT_FADD, 2, cycles from issue to fadd slice valid
- LAT_FSUB, 2, fsub latency
- LAT_FDIV, 6, fdiv latency
- LAT_FSQRT, 6, fsqrt latency
- LAT_FCVTWS, 3, fcvt.w.s latency
- LAT_FCVTSW, 2, fcvt.s.w latency
- LAT_FMUL, 2, fmul latency
- MAX_LAT, 8, slot-pipeline depth; every LAT_* must satisfy 1 <= LAT_* <= MAX_LAT

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  op offered this cycle
- issue_op  in  3  0 fadd, 1 fsub, 2 fdiv, 3 fsqrt, 4 fcvtws, 5 fcvtsw, 6 fmul, 7 none
- issue_rd  in  5  destination register index
- issue_ready  out  1  op accepted when issue_valid && issue_ready
- flush  in  1  discard all in-flight ops
- fpu_results  in  224  [31:0] fadd, [63:32] fsub, [95:64] fdiv, [127:96] fsqrt, [159:128] fcvtws, [191:160] fcvtsw, [223:192] fmul
- wb_valid  out  1  writeback strobe (registered)
- wb_rd  out  5  writeback destination
- wb_int  out  1  1 = integer register file (fcvtws), 0 = FP file
- wb_data  out  32  writeback value
- busy  out  32  bit i set while an op targeting index i is in flight

Behaviour:
- Timing: the issue cycle is cycle 0. The op's slice is valid on fpu_results in cycle LAT only.
- Slot pipeline: slot[0..MAX_LAT-1], each holding {valid, op, rd}.
  - On every edge, slot[i] <= slot[i+1] and slot[MAX_LAT-1] <= empty.
  - An accepted op with latency L is written into slot[L-1], overriding the shift.
  - The entry therefore reaches slot[0] in cycle L.
- Writeback: when slot[0].valid in cycle L, on the next edge register:
  - wb_valid <= 1
  - wb_rd <= slot[0].rd
  - wb_int <= (op == 4)
  - wb_data <= slice[op]
  - Outputs are visible in cycle L+1. Otherwise wb_valid <= 0; wb_rd, wb_int and wb_data hold their previous values.
- issue_ready = !(slot[L].valid when L < MAX_LAT) && !busy[issue_rd] && !flush.
  - Combinational from state, issue_op, issue_rd and flush; independent of issue_valid.
  - The first term is the writeback-collision check; the second blocks WAW.
- issue_op == 7: issue_ready = 1, the handshake completes, no slot is allocated, busy is unchanged.
- Scoreboard: busy[rd] is set on the edge that accepts an op.
  - It is cleared on the edge where that entry leaves slot[0], i.e. together with the wb_valid register load.
  - If a set and a clear hit the same index on the same edge, set wins. This cannot occur under WAW blocking; implement it anyway.
  - busy is shared across the integer and FP indices and is deliberately conservative.
- At most one writeback per cycle is guaranteed by construction.
  - The bench asserts that no two slot writes ever target the same slot on one edge.
- Flush: on the edge with flush = 1, all slots go invalid, busy <= 0, wb_valid <= 0, and no issue is accepted.
  - A writeback registered on the previous edge still presents for its cycle.
- Reset (rst = 1 at an edge, including mid-flight):
  - All slots invalid; busy = 0; wb_valid = 0; wb_rd = 0; wb_int = 0; wb_data = 0.
  - issue_ready evaluates from the cleared state, so it is 1 for ops 0–7 in the cycle after reset.
- Rst has priority over flush; flush has priority over issue.

Test Plan:
- Reset, then fadd rd=3 in cycle 0 with slice0 = 0x3F800000 only in cycle 2:
  - wb_valid=1, wb_rd=3, wb_int=0, wb_data=0x3F800000 in cycle 3.
  - busy[3] is 1 in cycles 1–2 and 0 from cycle 3.
- fadd rd=1 and fmul rd=2 on consecutive cycles 0 and 1 -> writebacks in cycles 3 and 4 with the correct slices, issue_ready high throughout.
- fdiv rd=5 in cycle 0, fadd rd=6 offered from cycle 4:
  - issue_ready=0 in cycle 4 (collision at cycle 6).
  - Accepted in cycle 5; writebacks rd=5 in cycle 7, rd=6 in cycle 8.
- fmul rd=7 in cycle 0, fsub rd=7 offered in cycle 1 -> issue_ready=0 while busy[7]=1; accepted in cycle 3.
- fcvtws rd=9 in cycle 0 -> wb_int=1, wb_rd=9, data from [159:128] in cycle 4.
- fsqrt rd=4 in cycle 0 with flush in cycle 3 (or rst in cycle 3):
  - No writeback ever occurs; busy=0 from cycle 4.
  - op 7 in cycle 4 is accepted with no wb and no busy change.
